wso_capture_deserializer: RTL
=============================

# wso_capture_deserializer

Serial-in/parallel-out receiver for the IEEE 1500 wrapper serial path. It samples the wrapper's WSO output on WRCK while shifting is enabled and assembles SIZE-bit words. Each completed word is presented on a valid/ready parallel interface. It is the receiving counterpart of the parallel-load serial shifter that drives WSI, and lets benches and on-chip test logic read back WIR, WBY and WBR contents without manual waveform inspection.

## Interface
- SIZE, 12: word width in bits; legal range 2..32.
- WRCK  input  1  wrapper clock; all state updates on rising edge.
- WRSTN  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear: aborts any partial word and drops data_valid; does not clear overrun.
- shift_en  input  1  qualifies sampling of WSO; normally tied to ShiftWR.
- WSO  input  1  serial data from the wrapper.
- data_ready  input  1  consumer accepts data_out when it is high together with data_valid.
- data_out  output  SIZE  last completed word.
- data_valid  output  1  data_out holds an unconsumed word.
- busy  output  1  a partial word is in progress (state SHIFT).
- frame_err  output  1  one-cycle pulse: shift_en fell with a partial word pending.
- overrun  output  1  sticky: a word completed while the previous word was unconsumed.

## Operation
- FSM states are IDLE and SHIFT. Reset enters IDLE.
- IDLE:
  - shift_en=1: sample WSO into the shift register, set bit_cnt=1, go to SHIFT.
  - Otherwise hold.
- SHIFT:
  - shift_en=1: shift WSO in, bit_cnt+1.
  - When the sampled bit is number SIZE, complete the word, set bit_cnt=0 and stay in SHIFT. Back-to-back words need no gap cycle.
  - shift_en=0 with 0 < bit_cnt < SIZE: discard the partial word, pulse frame_err, go to IDLE.
  - shift_en=0 with bit_cnt=0: go to IDLE with no error.
- Bit order is MSB first. The first sampled bit ends up in data_out[SIZE-1] and the last in data_out[0].
- bit_cnt is $clog2(SIZE+1) bits wide and wraps to 0 at word completion.
- Word completion:
  - If data_valid=0, or data_valid=1 with data_ready=1 in the same cycle: load data_out and set data_valid=1.
  - Otherwise keep the old data_out, drop the new word and set overrun=1.
- Consumption: data_valid=1 and data_ready=1 with no completion in that cycle clears data_valid.
- clr has priority over shifting and completion. It forces IDLE, bit_cnt=0 and data_valid=0, and keeps data_out and overrun.
- overrun is cleared only by WRSTN.

## Timing
- Reset values: data_out=0, data_valid=0, busy=0, frame_err=0, overrun=0, bit_cnt=0, state IDLE.
- WSO is sampled at the WRCK rising edge. It must be stable around that edge, i.e. the wrapper launches WSO on the falling edge.
- Latency: data_out and data_valid update on the same edge that samples bit SIZE, visible immediately after it.
- With shift_en held high, a word completes every SIZE cycles.
- WRSTN asserted mid-word: immediate asynchronous return to reset values. The partial word is lost and no frame_err is raised.
- frame_err is high for exactly one cycle, the cycle after the edge on which shift_en=0 was sampled.

## Configuration
- COMPARE_EN defined adds:
  - input expected[SIZE-1:0];
  - output mismatch, a 1-cycle pulse at completion when the shifted word differs from expected;
  - output err_cnt[7:0], saturating at 255 and reset to 0 by WRSTN.
  - expected is sampled on the completion edge.
- COMPARE_EN undefined: those ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package wrapper_test_pkg:
  - state enum (IDLE, SHIFT);
  - default word width constant, 12;
  - function computing the counter width from SIZE.
- Single module. The shift register, counter and FSM are inlined. An optional sub-module wso_word_compare implements the COMPARE_EN logic.

## Test plan
- Reset check: hold WRSTN=0, toggle WSO, shift_en=1 → all outputs 0.
- Single word: after reset, shift 12'b101100010100 MSB first with shift_en high for 12 cycles → data_out=12'hB14, data_valid=1 after edge 12, busy=1 during edges 1–11.
- Back-to-back words with data_ready=1: shift 12'hB14 then 12'h0FF continuously → two completions 12 cycles apart, data_out=12'h0FF at the end, overrun=0.
- Overrun: data_ready=0 while shifting 12'hB14 then 12'hAAA → data_out stays 12'hB14, overrun=1 and stays 1 after data_ready=1.
- Abort: drop shift_en after 5 bits → one frame_err pulse, state IDLE, data_valid unchanged. A following full word of 12'h123 → data_out=12'h123.
- COMPARE_EN: expected=12'hB14, shift 12'hB15 → mismatch pulse, err_cnt=1. Shift 12'hB14 → no pulse, err_cnt stays 1.

Source files
------------

// File: rtl/wrapper_test_pkg.sv
// Shared types and constants for the IEEE 1500 wrapper serial-path test blocks.
package wrapper_test_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_SIZE = 12;

    // bit_cnt must be able to hold the value SIZE itself
    function automatic int cnt_width(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/wso_word_compare.sv
// Compares each completed word with an expected value; pulses mismatch and
// keeps a saturating error count. Only instantiated when COMPARE_EN is defined.
module wso_word_compare
    import wrapper_test_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic            WRCK,
    input  logic            WRSTN,
    input  logic            complete,
    input  logic [SIZE-1:0] word,
    input  logic [SIZE-1:0] expected,
    output logic            mismatch,
    output logic [7:0]      err_cnt
);

    logic [SIZE-1:0] diff;
    logic            mismatch_reg;
    logic [7:0]      err_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_diff
            assign diff[gi] = word[gi] ^ expected[gi];
        end
    endgenerate

    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            mismatch_reg <= 1'b0;
            err_cnt_reg  <= 8'd0;
        end else begin
            mismatch_reg <= complete && (|diff);
            if (complete && (|diff) && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign mismatch = mismatch_reg;
    assign err_cnt  = err_cnt_reg;

endmodule

// File: rtl/wso_capture_deserializer.sv
// Serial-in/parallel-out receiver for the wrapper WSO path, MSB first, with a
// valid/ready output. Optional expected-value checking under `define COMPARE_EN.
module wso_capture_deserializer
    import wrapper_test_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic            WRCK,
    input  logic            WRSTN,
    input  logic            clr,
    input  logic            shift_en,
    input  logic            WSO,
    input  logic            data_ready,
`ifdef COMPARE_EN
    input  logic [SIZE-1:0] expected,
    output logic            mismatch,
    output logic [7:0]      err_cnt,
`endif
    output logic [SIZE-1:0] data_out,
    output logic            data_valid,
    output logic            busy,
    output logic            frame_err,
    output logic            overrun
);

    localparam int CW = cnt_width(SIZE);
    localparam logic [CW-1:0] LAST_CNT = CW'(SIZE - 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [SIZE-2:0] shift_reg, shift_next;
    logic [SIZE-1:0] word;
    logic            complete;
    logic            abort;

    logic [SIZE-1:0] data_out_reg;
    logic            data_valid_reg;
    logic            frame_err_reg;
    logic            overrun_reg;

    // The incoming bit is appended below the bits already held
    assign word = {shift_reg, WSO};

    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        complete     = 1'b0;
        abort        = 1'b0;
        if (clr) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (shift_en) begin
                        shift_next   = word[SIZE-2:0];
                        bit_cnt_next = CW'(1);
                        state_next   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        shift_next = word[SIZE-2:0];
                        if (bit_cnt_reg == LAST_CNT) begin
                            complete     = 1'b1;
                            bit_cnt_next = '0;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + CW'(1);
                        end
                    end else begin
                        abort        = (bit_cnt_reg != '0);
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    bit_cnt_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy = (state_reg == SHIFT);
    end

    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            frame_err_reg <= abort;
            if (clr) begin
                data_valid_reg <= 1'b0;
            end else if (complete) begin
                // A handshake in the same cycle frees the slot for the new word
                if (!data_valid_reg || data_ready) begin
                    data_out_reg   <= word;
                    data_valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (data_valid_reg && data_ready) begin
                data_valid_reg <= 1'b0;
            end
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;

`ifdef COMPARE_EN
    wso_word_compare #(
        .SIZE(SIZE)
    ) u_compare (
        .WRCK     (WRCK),
        .WRSTN    (WRSTN),
        .complete (complete),
        .word     (word),
        .expected (expected),
        .mismatch (mismatch),
        .err_cnt  (err_cnt)
    );
`endif

endmodule
